// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned CTR_W  = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  function automatic grant_t fixed_grant(input logic dreq);
    return dreq ? GNT_D : GNT_I;
  endfunction

  // On a tie the requester that was not granted last time wins.
  function automatic grant_t rr_grant(input logic ireq, input logic dreq, input grant_t last);
    if (ireq && dreq) return (last == GNT_D) ? GNT_I : GNT_D;
    return fixed_grant(dreq);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Registered request/ready bus between the arbiter (master) and the memory (slave).
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;
  logic          MemReady;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemRData, MemReady
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemRData, MemReady
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// 8-bit per-transaction down-counter; expired is high while the count is zero.
module memarb_timeout_ctr
  import mips_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for one single-ported memory with a per-access timeout.
// Define MEMARB_RR_EN for round-robin on ties; default is fixed D-over-I priority.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IReady,
  output logic [DW-1:0] IRData,
  output logic          IWait,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DReady,
  output logic [DW-1:0] DRData,
  output logic          DWait,
  output logic          Err,
  mem_port_arbiter_if.master mem
);

  arb_state_t    state, next_state;
  grant_t        gnt, sel;
  logic          req_any, ctr_load, ctr_en, expired;
  logic          done, hit, timed_out;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  assign req_any = IReq | DReq;

`ifdef MEMARB_RR_EN
  grant_t last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_gnt <= GNT_D;
    else if (ctr_load) last_gnt <= sel;
  end

  always_comb sel = rr_grant(IReq, DReq, last_gnt);
`else
  always_comb sel = fixed_grant(DReq);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_any) next_state = ISSUE;
      ISSUE:   if (mem.MemReady || expired) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MemReady wins over expiry when both land on the same edge.
  always_comb begin
    ctr_load  = (state == IDLE) && req_any;
    ctr_en    = (state == ISSUE) && !mem.MemReady;
    hit       = (state == ISSUE) && mem.MemReady;
    done      = (state == ISSUE) && (mem.MemReady || expired);
    timed_out = (state == ISSUE) && !mem.MemReady && expired;
  end

  memarb_timeout_ctr u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (CTR_W'(TIMEOUT)),
    .en       (ctr_en),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt         <= GNT_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      IReady      <= 1'b0;
      DReady      <= 1'b0;
      Err         <= 1'b0;
      IRData      <= '0;
      DRData      <= '0;
    end else begin
      mem_req_q <= (next_state == ISSUE);
      if (ctr_load) begin
        gnt         <= sel;
        mem_we_q    <= (sel == GNT_D) && DWe;
        mem_addr_q  <= (sel == GNT_D) ? DAddr : IAddr;
        mem_wdata_q <= (sel == GNT_D) ? DWData : '0;
      end
      IReady <= done && (gnt == GNT_I);
      DReady <= done && (gnt == GNT_D);
      if (done) Err <= timed_out;
      if (hit && (gnt == GNT_I)) IRData <= mem.MemRData;
      if (hit && (gnt == GNT_D) && !mem_we_q) DRData <= mem.MemRData;
    end
  end

  assign mem.MemReq   = mem_req_q;
  assign mem.MemWe    = mem_we_q;
  assign mem.MemAddr  = mem_addr_q;
  assign mem.MemWData = mem_wdata_q;

  assign IWait = IReq & ~IReady;
  assign DWait = DReq & ~DReady;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model (TIMEOUT=4).
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWData;
  logic        IReady, IWait, DReady, DWait, Err;
  logic [31:0] IRData, DRData;

  mem_port_arbiter_if #(.AW(32), .DW(32)) mem_bus ();

  mem_port_arbiter #(.TIMEOUT(TO), .AW(32), .DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .IReq   (IReq),
    .IAddr  (IAddr),
    .IReady (IReady),
    .IRData (IRData),
    .IWait  (IWait),
    .DReq   (DReq),
    .DWe    (DWe),
    .DAddr  (DAddr),
    .DWData (DWData),
    .DReady (DReady),
    .DRData (DRData),
    .DWait  (DWait),
    .Err    (Err),
    .mem    (mem_bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_ird, exp_drd;
`ifdef MEMARB_RR_EN
  bit rr_last;  // 1 = D was granted last
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns 1 when D should be served first.
  function automatic bit first_is_d(input bit ri, input bit rd);
`ifdef MEMARB_RR_EN
    if (ri && rd) return !rr_last;
`else
    if (ri && rd) return 1'b1;
`endif
    return rd;
  endfunction

  // One scenario: raise the chosen requests, play memory with the given wait counts
  // (a wait above TO means MemReady never comes), and check every cycle.
  task automatic run_case(input bit ri, input bit rd, input bit we,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                          input int unsigned wi, input int unsigned wdw,
                          input bit fix_resp, input logic [31:0] resp_val);
    bit          order[2];
    int          n, k, rise, d;
    bit          g, err, in_issue, rdy, done_all;
    int unsigned w;
    logic [31:0] resp;
    n = 0;
    if (ri && rd) begin
      order[0] = first_is_d(1'b1, 1'b1);
      order[1] = !order[0];
      n = 2;
    end else if (ri || rd) begin
      order[0] = rd;
      order[1] = rd;
      n = 1;
    end
    if (n == 0) return;
    IReq = ri; IAddr = ia; DReq = rd; DWe = we; DAddr = da; DWData = wd;
    k = 0; rise = 1; done_all = 1'b0; resp = '0;
    for (int cyc = 1; cyc <= 80 && !done_all; cyc++) begin
      @(posedge clk); #1;
      g        = order[k];
      w        = g ? wdw : wi;
      err      = (w > TO);
      d        = err ? int'(TO) + 1 : int'(w) + 1;
      in_issue = (cyc >= rise) && (cyc < rise + d);
      rdy      = (cyc == rise + d);
      check_eq("mem_req", mem_bus.MemReq, in_issue);
      if (in_issue) begin
        check_eq("mem_addr", mem_bus.MemAddr, g ? da : ia);
        check_eq("mem_we", mem_bus.MemWe, g && we);
        if (g) check_eq("mem_wdata", mem_bus.MemWData, wd);
      end
      check_eq("i_ready", IReady, rdy && !g);
      check_eq("d_ready", DReady, rdy && g);
      check_eq("i_wait", IWait, IReq && !(rdy && !g));
      check_eq("d_wait", DWait, DReq && !(rdy && g));
      if (rdy) begin
        check_eq("err", Err, err);
        if (!err) begin
          if (!g)      exp_ird = resp;
          else if (!we) exp_drd = resp;
        end
      end
      check_eq("i_rdata", IRData, exp_ird);
      check_eq("d_rdata", DRData, exp_drd);
      if (cyc == rise) resp = fix_resp ? resp_val : $urandom;
      if (in_issue && !err && (cyc == rise + int'(w))) begin
        mem_bus.MemReady = 1'b1;
        mem_bus.MemRData = resp;
      end else begin
        mem_bus.MemReady = !in_issue && ($urandom_range(0, 3) == 0);
        mem_bus.MemRData = $urandom;
      end
      if (rdy) begin
        if (!g) IReq = 1'b0;
        else    DReq = 1'b0;
`ifdef MEMARB_RR_EN
        rr_last = g;
`endif
        k++;
        rise = cyc + 2;
        if (k == n) done_all = 1'b1;
      end
    end
    if (!done_all) check_eq("txn_budget", 32'd0, 32'd1);
    IReq = 1'b0; DReq = 1'b0;
    mem_bus.MemReady = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_mem_req", mem_bus.MemReq, 1'b0);
    check_eq("idle_ready", {31'd0, IReady | DReady}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ri, rd, we;
    int unsigned t, wi, wdw;
    rst = 1'b1;
    IReq = 1'b0; DReq = 1'b0; DWe = 1'b0;
    IAddr = '0; DAddr = '0; DWData = '0;
    mem_bus.MemReady = 1'b0;
    mem_bus.MemRData = '0;
    exp_ird = '0; exp_drd = '0;
`ifdef MEMARB_RR_EN
    rr_last = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_req", mem_bus.MemReq, 1'b0);
    check_eq("rst_mem_we", mem_bus.MemWe, 1'b0);
    check_eq("rst_mem_addr", mem_bus.MemAddr, 32'd0);
    check_eq("rst_ready", {30'd0, IReady, DReady}, 32'd0);
    check_eq("rst_err", Err, 1'b0);
    check_eq("rst_i_rdata", IRData, 32'd0);
    check_eq("rst_d_rdata", DRData, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_case(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 0, 0, 1, 32'h8C08_0004);
    check_eq("fetch_word", IRData, 32'h8C08_0004);
    run_case(1, 1, 0, 32'h0040_0000, 32'h1001_0000, 32'h0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      run_case(1, 1, 0, 32'h0040_0010 + 32'(i), 32'h1001_0020 + 32'(i), 32'h0, 1, 0, 0, 32'h0);
    run_case(0, 1, 1, 32'h0, 32'h1001_0040, 32'hDEAD_BEEF, 0, 4, 0, 32'h0);
    run_case(0, 1, 0, 32'h0, 32'h1001_0044, 32'h0, 0, TO + 3, 0, 32'h0);
    run_case(1, 0, 0, 32'h0040_0020, 32'h0, 32'h0, TO, 0, 0, 32'h0);
    run_case(1, 1, 1, 32'h0040_0024, 32'h1001_0048, 32'h1234_5678, TO + 1, TO + 1, 0, 32'h0);

    // Reset in the middle of an access
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h1001_0050;
    @(posedge clk); #1;
    check_eq("pre_rst_mem_req", mem_bus.MemReq, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_mem_req", mem_bus.MemReq, 1'b0);
    check_eq("async_rst_ready", {30'd0, IReady, DReady}, 32'd0);
    check_eq("async_rst_d_rdata", DRData, 32'd0);
    check_eq("async_rst_i_rdata", IRData, 32'd0);
    exp_ird = '0; exp_drd = '0;
`ifdef MEMARB_RR_EN
    rr_last = 1'b1;
`endif
    DReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_mem_req", mem_bus.MemReq, 1'b0);
    check_eq("post_rst_ready", {30'd0, IReady, DReady}, 32'd0);
    run_case(0, 1, 0, 32'h0, 32'h1001_0054, 32'h0, 2, 2, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      t   = $urandom_range(0, 3);
      ri  = (t != 1);
      rd  = (t != 0);
      we  = $urandom_range(0, 1) == 1;
      wi  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 3);
      wdw = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 3);
      run_case(ri, rd, we, $urandom, $urandom, $urandom, wi, wdw, 0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
